// File: rtl/lab1_imul_accum_pkg.sv
// lab1_imul_accum_pkg: FSM state type and default parameters shared by the product accumulator files
package lab1_imul_accum_pkg;
  typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} accum_state_t;
  localparam int unsigned P_NBITS      = 32;
  localparam int unsigned P_GROUP_SIZE = 4;
  localparam int unsigned P_CNT_NBITS  = 8;
endpackage

// File: rtl/lab1_imul_accum_dpath.sv
// lab1_imul_accum_dpath: acc/cnt/carry registers and (p_nbits+1)-bit adder; ports clk, reset (async low), add_en, clr, in_msg -> acc, cnt, carry
module lab1_imul_accum_dpath
  import lab1_imul_accum_pkg::*;
#(
  parameter int unsigned p_nbits     = P_NBITS,
  parameter int unsigned p_cnt_nbits = P_CNT_NBITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   add_en,
  input  logic                   clr,
  input  logic [p_nbits-1:0]     in_msg,
  output logic [p_nbits-1:0]     acc,
  output logic [p_cnt_nbits-1:0] cnt,
  output logic                   carry
);
  logic [p_nbits:0]       sum;
  logic [p_nbits-1:0]     acc_q, acc_d;
  logic [p_cnt_nbits-1:0] cnt_q, cnt_d;
  logic                   carry_q, carry_d;
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, in_msg};
    acc_d   = clr ? '0 : add_en ? sum[p_nbits-1:0] : acc_q;
    cnt_d   = clr ? '0 : add_en ? cnt_q + p_cnt_nbits'(1) : cnt_q;
    carry_d = clr ? 1'b0 : add_en ? carry_q | sum[p_nbits] : carry_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  assign acc   = acc_q;
  assign cnt   = cnt_q;
  assign carry = carry_q;
endmodule

// File: rtl/lab1_imul_prod_accum.sv
// lab1_imul_prod_accum: groups products from istream (val/rdy/msg, flush) into mod-2^n sums on ostream (val/rdy/msg/len/carry); clk, async active-low reset
module lab1_imul_prod_accum
  import lab1_imul_accum_pkg::*;
#(
  parameter int unsigned p_nbits      = P_NBITS,
  parameter int unsigned p_group_size = P_GROUP_SIZE,
  parameter int unsigned p_cnt_nbits  = P_CNT_NBITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   istream_val,
  output logic                   istream_rdy,
  input  logic [p_nbits-1:0]     istream_msg,
  input  logic                   flush,
  output logic                   ostream_val,
  input  logic                   ostream_rdy,
  output logic [p_nbits-1:0]     ostream_msg,
  output logic [p_cnt_nbits-1:0] ostream_len,
  output logic                   ostream_carry
);
  accum_state_t state_q, state_d;
  logic in_fire, out_fire, close;
  always_comb begin
    istream_rdy = reset && state_q == ACCUM;
    ostream_val = state_q == EMIT;
    in_fire     = istream_val && istream_rdy;
    out_fire    = ostream_val && ostream_rdy;
    close       = (in_fire && ostream_len + p_cnt_nbits'(1) == p_cnt_nbits'(p_group_size))
               || (flush && (ostream_len != '0 || in_fire));
    state_d     = state_q == ACCUM ? (close ? EMIT : ACCUM) : (out_fire ? ACCUM : EMIT);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= ACCUM;
    else        state_q <= state_d;
  lab1_imul_accum_dpath #(.p_nbits(p_nbits), .p_cnt_nbits(p_cnt_nbits)) u_dpath (
    .clk    (clk),
    .reset  (reset),
    .add_en (in_fire),
    .clr    (out_fire),
    .in_msg (istream_msg),
    .acc    (ostream_msg),
    .cnt    (ostream_len),
    .carry  (ostream_carry)
  );
endmodule

// File: tb/tb_lab1_imul_prod_accum.sv
// tb_lab1_imul_prod_accum: directed and randomized checks of the product accumulator (group sizes 4 and 3)
module tb_lab1_imul_prod_accum;
  logic clk = 1'b0, reset = 1'b0;
  logic a_val = 1'b0, a_irdy, a_flush = 1'b0, a_oval, a_ordy = 1'b1, a_carry;
  logic [31:0] a_msg = '0, a_omsg;
  logic [7:0] a_len;
  logic b_val = 1'b0, b_irdy, b_flush = 1'b0, b_oval, b_ordy = 1'b1, b_carry;
  logic [31:0] b_msg = '0, b_omsg;
  logic [7:0] b_len;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  lab1_imul_prod_accum #(.p_nbits(32), .p_group_size(4), .p_cnt_nbits(8)) dut_a (
    .clk(clk), .reset(reset), .istream_val(a_val), .istream_rdy(a_irdy), .istream_msg(a_msg),
    .flush(a_flush), .ostream_val(a_oval), .ostream_rdy(a_ordy), .ostream_msg(a_omsg),
    .ostream_len(a_len), .ostream_carry(a_carry));
  lab1_imul_prod_accum #(.p_nbits(32), .p_group_size(3), .p_cnt_nbits(8)) dut_b (
    .clk(clk), .reset(reset), .istream_val(b_val), .istream_rdy(b_irdy), .istream_msg(b_msg),
    .flush(b_flush), .ostream_val(b_oval), .ostream_rdy(b_ordy), .ostream_msg(b_omsg),
    .ostream_len(b_len), .ostream_carry(b_carry));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic feed(input logic [31:0] p, input logic f);
    for (int i = 0; i < 50 && !a_irdy; i++) begin
      @(posedge clk); #1;
    end
    chk("feed_rdy", 32'(a_irdy), 1);
    a_val = 1'b1; a_msg = p; a_flush = f;
    @(posedge clk); #1;
    a_val = 1'b0; a_flush = 1'b0;
  endtask
  task automatic feed_b(input logic [31:0] p);
    b_val = 1'b1; b_msg = p;
    @(posedge clk); #1;
    b_val = 1'b0;
  endtask
  logic [31:0] msum, x, y;
  logic [32:0] t;
  logic mcar, inf, outf;
  int mcnt, ngroups;
  initial begin
    #3;
    chk("rst_irdy", 32'(a_irdy), 0);
    chk("rst_oval", 32'(a_oval), 0);
    chk("rst_omsg", a_omsg, 0);
    chk("rst_len", 32'(a_len), 0);
    chk("rst_carry", 32'(a_carry), 0);
    #9 reset = 1'b1;
    #1 chk("rel_irdy", 32'(a_irdy), 1);
    @(posedge clk); #1;
    feed(3, 0); feed(5, 0); feed(7, 0);
    chk("full_early_oval", 32'(a_oval), 0);
    feed(11, 0);
    chk("full_oval", 32'(a_oval), 1);
    chk("full_msg", a_omsg, 26);
    chk("full_len", 32'(a_len), 4);
    chk("full_carry", 32'(a_carry), 0);
    chk("full_irdy", 32'(a_irdy), 0);
    @(posedge clk); #1;
    chk("full_after_oval", 32'(a_oval), 0);
    chk("full_after_irdy", 32'(a_irdy), 1);
    feed(32'hFFFF_FFFF, 0); feed(2, 0); feed(1, 0); feed(1, 0);
    chk("wrap_msg", a_omsg, 3);
    chk("wrap_carry", 32'(a_carry), 1);
    chk("wrap_len", 32'(a_len), 4);
    feed(1, 0); feed(1, 0); feed(1, 0); feed(1, 0);
    chk("clr_msg", a_omsg, 4);
    chk("clr_carry", 32'(a_carry), 0);
    feed(9, 0); feed(4, 1);
    chk("flush_oval", 32'(a_oval), 1);
    chk("flush_msg", a_omsg, 13);
    chk("flush_len", 32'(a_len), 2);
    @(posedge clk); #1;
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("empty_flush_oval", 32'(a_oval), 0);
      @(posedge clk); #1;
    end
    a_ordy = 1'b0;
    feed(10, 0); feed(20, 0); feed(30, 0); feed(40, 0);
    a_val = 1'b1; a_msg = 100;
    for (int i = 0; i < 6; i++) begin
      chk("bp_oval", 32'(a_oval), 1);
      chk("bp_msg", a_omsg, 100);
      chk("bp_len", 32'(a_len), 4);
      chk("bp_irdy", 32'(a_irdy), 0);
      @(posedge clk); #1;
    end
    a_ordy = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_irdy", 32'(a_irdy), 1);
    @(posedge clk); #1;
    a_val = 1'b0;
    feed(1, 0); feed(2, 0); feed(3, 0);
    chk("bp_next_msg", a_omsg, 106);
    chk("bp_next_len", 32'(a_len), 4);
    feed_b(5); feed_b(6);
    chk("b_pre_irdy", 32'(b_irdy), 1);
    #2 reset = 1'b0;
    #1;
    chk("b_rst_irdy", 32'(b_irdy), 0);
    chk("b_rst_oval", 32'(b_oval), 0);
    chk("b_rst_msg", b_omsg, 0);
    chk("b_rst_len", 32'(b_len), 0);
    chk("b_rst_carry", 32'(b_carry), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    feed_b(1); feed_b(2);
    chk("b_mid_oval", 32'(b_oval), 0);
    feed_b(3);
    chk("b_oval", 32'(b_oval), 1);
    chk("b_msg", b_omsg, 6);
    chk("b_len", 32'(b_len), 3);
    chk("b_carry", 32'(b_carry), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    msum = '0; mcar = 1'b0; mcnt = 0; ngroups = 0;
    for (int i = 0; i < 800; i++) begin
      a_ordy = 1'($urandom_range(0, 1));
      if (!a_val && $urandom_range(0, 2) != 0) begin
        x = $urandom; y = $urandom;
        a_val = 1'b1; a_msg = x * y;
      end
      inf  = a_val && a_irdy;
      outf = a_oval && a_ordy;
      if (outf) begin
        chk("rnd_msg", a_omsg, msum);
        chk("rnd_len", 32'(a_len), 32'(mcnt));
        chk("rnd_carry", 32'(a_carry), 32'(mcar));
      end
      @(posedge clk); #1;
      if (outf) begin
        msum = '0; mcar = 1'b0; mcnt = 0; ngroups++;
      end
      if (inf) begin
        t = {1'b0, msum} + {1'b0, a_msg};
        msum = t[31:0]; mcar = mcar | t[32]; mcnt++;
        a_val = 1'b0;
      end
    end
    chk("rnd_groups", 32'(ngroups >= 20), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lab1_imul_prod_accum.md
# lab1_imul_prod_accum

Downstream consumer of the fixed-latency integer multiplier's response stream. It accepts 32-bit products over a val/rdy stream and accumulates groups of `p_group_size` products into a running sum modulo 2^32. It emits each completed sum, its product count and an unsigned-carry flag on a val/rdy output stream. A `flush` input closes a partial group early, which lets a dot-product front end end a vector of any length.

## Interface
- `p_nbits`, 32, width of products and of the sum
- `p_group_size`, 4, products per sum; legal range 1..255
- `p_cnt_nbits`, 8, width of the count field; must hold `p_group_size`
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-low reset; the single clock is `clk`
- `istream_val`  in  1  product valid
- `istream_rdy`  out  1  accumulator can accept a product
- `istream_msg`  in  `p_nbits`  product, unsigned
- `flush`  in  1  close the current group after this cycle
- `ostream_val`  out  1  sum valid
- `ostream_rdy`  in  1  consumer accepts the sum
- `ostream_msg`  out  `p_nbits`  accumulated sum mod 2^`p_nbits`
- `ostream_len`  out  `p_cnt_nbits`  number of products in the sum
- `ostream_carry`  out  1  sticky: some addition in this group carried out of bit `p_nbits-1`

## Operation
- State machine with two states, ACCUM and EMIT. Reset state is ACCUM.
- ACCUM:
  - `istream_rdy`=1, `ostream_val`=0.
  - On a fire (val&&rdy): `acc <= acc + istream_msg`, `cnt <= cnt + 1`, and `carry |=` carry-out of that addition.
- ACCUM to EMIT when either condition holds:
  - a fire brings `cnt+1 == p_group_size`; or
  - `flush`=1 and the group is non-empty after this cycle (`cnt != 0`, or a fire happens this cycle).
- `flush` with an empty group and no fire is ignored; zero-length sums are never emitted.
- `flush` together with a fire: the product is included, then the group closes.
- EMIT:
  - `istream_rdy`=0, `ostream_val`=1.
  - `ostream_msg`=acc, `ostream_len`=cnt, `ostream_carry`=carry, all held stable until the output fires.
  - `flush` is ignored in EMIT.
- EMIT to ACCUM on an output fire. In the same edge, acc, cnt and carry clear to 0.
- The sum is unsigned, modulo 2^`p_nbits`. It wraps silently, and the wrap is reported only through `ostream_carry`.

## Timing
- While `reset`=0, asynchronously: state=ACCUM, acc=0, cnt=0, carry=0.
- Outputs during reset: `istream_rdy`=0 (gated by reset), `ostream_val`=0, `ostream_msg`=0, `ostream_len`=0, `ostream_carry`=0.
- Deasserting reset returns `istream_rdy` to 1 combinationally.
- Reset asserted in the middle of a group or during EMIT discards all accumulated state. No partial sum is emitted.
- Latency: if the closing product fires at edge N, `ostream_val` is high in the cycle after edge N.
- Throughput: a full group needs at least `p_group_size`+1 cycles. There is no overlap between EMIT and accepting the next group.
- Backpressure: EMIT is held indefinitely while `ostream_rdy`=0. `istream_rdy` stays 0 for that whole time.
- `ostream_*` are driven from registers only. `istream_rdy` and `ostream_val` are decoded from state only, with no combinational path from `ostream_rdy` or `istream_val`.

## Structure
- Package `lab1_imul_accum_pkg` holds the state typedef `accum_state_t` (ACCUM=1'b0, EMIT=1'b1) and default parameter constants.
- Sub-module `lab1_imul_accum_dpath` holds the following, each with async active-low reset:
  - the acc register;
  - the cnt register;
  - the carry register;
  - the (`p_nbits`+1)-bit adder.
- Control (state register, next-state logic, outputs) lives in the top module.
- The library `vc_` registers and counter are not used because they reset synchronously.

## Test plan
- Full group, default parameters: products 3, 5, 7, 11 back to back with `ostream_rdy`=1.
  - Required: `ostream_msg`=26, `len`=4, `carry`=0.
  - `ostream_val` rises the cycle after the fourth fire, and `istream_rdy`=0 for exactly that one cycle.
- Wrap: products 0xFFFF_FFFF, 0x0000_0002, 1, 1.
  - Required: `ostream_msg`=0x0000_0003, `carry`=1.
  - The next group 1, 1, 1, 1 must give `msg`=4, `carry`=0, which proves carry clears.
- Flush:
  - Products 9 and 4, with `flush` on the second fire. Required: `msg`=13, `len`=2.
  - Then `flush` alone while empty. Required: no `ostream_val` for 5 cycles.
- Backpressure: hold `ostream_rdy`=0 for 6 cycles during EMIT while `istream_val`=1 with product 100.
  - Required: sum and len are stable and `istream_rdy` stays 0.
  - After release, the product 100 is accepted as the first product of the next group.
- Async reset, `p_group_size`=3: assert `reset`=0 between clock edges after 2 products.
  - Required: outputs go to 0 immediately.
  - After release, products 1, 2, 3 yield `msg`=6, `len`=3.
- Integration: place the block behind the multiplier with random operand pairs and random source/sink delays.
  - Required: each emitted sum equals the reference-model sum of its `p_group_size` products mod 2^32.
